// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: registered owner, optional lock, registered read return.
// Optional ARB_ROUND_ROBIN_EN: simultaneous unlocked requests alternate instead of fixed m0 priority.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_req,
   input  logic                m0_lock,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_gnt,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_rvalid,
   input  logic                m1_req,
   input  logic                m1_lock,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_gnt,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_rvalid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wenable,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

   typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

   owner_t     owner_q, owner_d, oth_own, pick;
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic       cur_req, cur_lock, oth_req;
   logic       rd0_p0, rd1_p0;
`ifdef ARB_ROUND_ROBIN_EN
   logic       last_q;
`endif

   always_comb begin
      pick = NONE;
      if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick = last_q ? OWN0 : OWN1;
`else
         pick = OWN0;
`endif
      end else if (m0_req) begin
         pick = OWN0;
      end else if (m1_req) begin
         pick = OWN1;
      end
   end

   always_comb begin
      cur_req  = 1'b0;
      cur_lock = 1'b0;
      oth_req  = 1'b0;
      oth_own  = NONE;
      case (owner_q)
         OWN0: begin
            cur_req = m0_req; cur_lock = m0_lock; oth_req = m1_req; oth_own = OWN1;
         end
         OWN1: begin
            cur_req = m1_req; cur_lock = m1_lock; oth_req = m0_req; oth_own = OWN0;
         end
         default: ;
      endcase
   end

   // An unlocked handover goes through NONE; an expired lock hands over directly so the waiter is served.
   always_comb begin
      owner_d    = owner_q;
      lock_cnt_d = '0;
      if (owner_q == NONE || !cur_req) begin
         owner_d = pick;
      end else if (cur_lock && lock_cnt_q < LOCK_LAST) begin
         lock_cnt_d = lock_cnt_q + 8'd1;
      end else if (oth_req) begin
         owner_d = cur_lock ? oth_own : NONE;
      end else if (cur_lock) begin
         lock_cnt_d = lock_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q    <= NONE;
         lock_cnt_q <= '0;
      end else begin
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_q <= 1'b1;
      else if (m0_gnt) last_q <= 1'b0;
      else if (m1_gnt) last_q <= 1'b1;
   end
`endif

   assign m0_gnt = (owner_q == OWN0) && m0_req;
   assign m1_gnt = (owner_q == OWN1) && m1_req;

   always_comb begin
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wenable = '0;
      case (owner_q)
         OWN0: begin
            mem_addr = m0_addr; mem_wdata = m0_wdata; mem_wenable = m0_req ? m0_wstrb : '0;
         end
         OWN1: begin
            mem_addr = m1_addr; mem_wdata = m1_wdata; mem_wenable = m1_req ? m1_wstrb : '0;
         end
         default: ;
      endcase
   end

   assign rd0_p0 = m0_gnt && (m0_wstrb == '0);
   assign rd1_p0 = m1_gnt && (m1_wstrb == '0);

   // grant cycle -> registered read return
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= rd0_p0;
         m1_rvalid <= rd1_p0;
         if (rd0_p0) m0_rdata <= mem_rdata;
         if (rd1_p0) m1_rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LOCK_MAX=4) with a small memory model and grant/read scoreboards.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_lock, m1_req, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wenable;

   logic [31:0] mem [0:255];
   int cyc = 0;
   int n_total = 0;
   int n_pass = 0;
   int n_fail = 0;

   typedef struct {int cyc; bit port; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wen;} gexp_t;
   typedef struct {int cyc; bit port; logic [31:0] data;} rexp_t;
   gexp_t gq[$];
   rexp_t rq[$];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = mem[mem_addr[9:2]];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[64] = 32'hDEADBEEF;
      mem[8]  = 32'h11223344;
      mem[16] = 32'h0BADF00D;
      forever begin
         @(posedge clk);
         for (int b = 0; b < 4; b++)
            if (mem_wenable[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic r, input logic l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      m0_req = r; m0_lock = l; m0_addr = a; m0_wdata = d; m0_wstrb = s;
   endtask

   task automatic drv1(input logic r, input logic l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      m1_req = r; m1_lock = l; m1_addr = a; m1_wdata = d; m1_wstrb = s;
   endtask

   task automatic exp_gnt(input int c, input bit p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      gexp_t g;
      g.cyc = c; g.port = p; g.addr = a; g.wdata = d; g.wen = w;
      gq.push_back(g);
   endtask

   task automatic exp_rd(input int c, input bit p, input logic [31:0] d);
      rexp_t r;
      r.cyc = c; r.port = p; r.data = d;
      rq.push_back(r);
   endtask

   task automatic abort(input logic [3:0] s);
      drv0(1'b1, 1'b0, 32'h100, 32'h55, s);
      tick;
      check("abort_gnt_pre", 32'(m0_gnt), 32'd1);
      check("abort_wen_pre", 32'(mem_wenable), 32'(s));
      #1 rst_n = 1'b0;
      #1;
      check("abort_gnt", 32'(m0_gnt), 32'd0);
      check("abort_wen", 32'(mem_wenable), 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;
      check("abort_rvalid", 32'(m0_rvalid), 32'd0);
      check("abort_rdata", m0_rdata, 32'd0);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      gexp_t g;
      rexp_t r;
      if (m0_gnt || m1_gnt) begin
         if (gq.size() == 0) check("gnt_unexpected", 32'({m1_gnt, m0_gnt}), 32'd0);
         else begin
            g = gq.pop_front();
            check("gnt_cycle", 32'(cyc), 32'(g.cyc));
            check("gnt_port", 32'({m1_gnt, m0_gnt}), g.port ? 32'd2 : 32'd1);
            check("gnt_addr", mem_addr, g.addr);
            check("gnt_wdata", mem_wdata, g.wdata);
            check("gnt_wen", 32'(mem_wenable), 32'(g.wen));
         end
      end else begin
         check("nogrant_wen", 32'(mem_wenable), 32'd0);
      end
      if (m0_rvalid || m1_rvalid) begin
         if (rq.size() == 0) check("rvalid_unexpected", 32'({m1_rvalid, m0_rvalid}), 32'd0);
         else begin
            r = rq.pop_front();
            check("rd_cycle", 32'(cyc), 32'(r.cyc));
            check("rd_port", 32'({m1_rvalid, m0_rvalid}), r.port ? 32'd2 : 32'd1);
            check("rd_data", r.port ? m1_rdata : m0_rdata, r.data);
         end
      end
   end

   initial begin
      int t;
      rst_n = 1'b0;
      drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;
      check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
      check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_wen", 32'(mem_wenable), 32'd0);
      rst_n = 1'b1;

      // Idle window
      repeat (10) begin
         tick;
         check("idle_addr", mem_addr, 32'd0);
         check("idle_outs", 32'({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}), 32'd0);
      end

      // Single m0 read
      t = cyc;
      drv0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      exp_gnt(t + 1, 1'b0, 32'h100, 32'h0, 4'h0);
      exp_rd(t + 2, 1'b0, 32'hDEADBEEF);
      tick;
      tick;
      drv0(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
      tick;
      check("rd_m1_rdata_quiet", m1_rdata, 32'd0);
      tick;

      // m1 byte write, then m0 reads it back
      t = cyc;
      drv1(1'b1, 1'b0, 32'h20, 32'hAA, 4'h1);
      exp_gnt(t + 1, 1'b1, 32'h20, 32'hAA, 4'h1);
      tick;
      tick;
      drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;
      t = cyc;
      drv0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      exp_gnt(t + 1, 1'b0, 32'h20, 32'h0, 4'h0);
      exp_rd(t + 2, 1'b0, 32'h112233AA);
      tick;
      tick;
      drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;

      // Tie: m0 first, m1 after an idle arbitration cycle
      t = cyc;
      drv0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      drv1(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      exp_gnt(t + 1, 1'b0, 32'h100, 32'h0, 4'h0);
      exp_rd(t + 2, 1'b0, 32'hDEADBEEF);
      exp_gnt(t + 3, 1'b1, 32'h40, 32'h0, 4'h0);
      exp_rd(t + 4, 1'b1, 32'h0BADF00D);
      tick;
      tick;
      drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;
      drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;

      // Lock limit: 4 locked m1 grants, forced m0 grant, then m1 holds while m0 idle
      t = cyc;
      drv1(1'b1, 1'b1, 32'h40, 32'h0, 4'h0);
      for (int i = 1; i <= 4; i++) exp_gnt(t + i, 1'b1, 32'h40, 32'h0, 4'h0);
      exp_gnt(t + 5, 1'b0, 32'h100, 32'h0, 4'h0);
      for (int i = 7; i <= 12; i++) exp_gnt(t + i, 1'b1, 32'h40, 32'h0, 4'h0);
      for (int i = 2; i <= 5; i++) exp_rd(t + i, 1'b1, 32'h0BADF00D);
      exp_rd(t + 6, 1'b0, 32'hDEADBEEF);
      for (int i = 8; i <= 13; i++) exp_rd(t + i, 1'b1, 32'h0BADF00D);
      tick;
      drv0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      repeat (5) tick;
      drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (7) tick;
      drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick;
      tick;

      // Reset in the middle of a read grant and of a write grant
      abort(4'h0);
      abort(4'hF);

      // First request after reset release
      t = cyc;
      drv1(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      exp_gnt(t + 1, 1'b1, 32'h40, 32'h0, 4'h0);
      exp_rd(t + 2, 1'b1, 32'h0BADF00D);
      tick;
      tick;
      drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) tick;

      check("gnt_queue_drained", 32'(gq.size()), 32'd0);
      check("rd_queue_drained", 32'(rq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
